// File: rtl/fir_deconv_if.sv
// fir_deconv_if: sample-in / sample-out handshake bundle for the FIR deconvolver.
// The block sits on the slave modport; the upstream/downstream environment uses master.
`default_nettype none

interface fir_deconv_if;
    logic signed [15:0] y_in;
    logic               y_valid;
    logic               y_ready;
    logic signed [7:0]  x_out;
    logic               x_valid;
    logic               x_ready;
    logic               x_ovf;

    modport master (
        output y_in, y_valid, x_ready,
        input  y_ready, x_out, x_valid, x_ovf
    );

    modport slave (
        input  y_in, y_valid, x_ready,
        output y_ready, x_out, x_valid, x_ovf
    );
endinterface

`default_nettype wire

// File: rtl/fir_deconv.sv
// ============================================================================
// Module  : fir_deconv
// Purpose : Inverts a 3-tap FIR, x[n] = K0*(y[n] - K1*x[n-1] - K2*x[n-2]),
//           one sample per 5 cycles. Macro FIR_DECONV_SAT_EN selects output
//           saturation; otherwise the result is truncated to 8 bits.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_deconv #(
    parameter int K0 = -1,
    parameter int K1 = 2,
    parameter int K2 = 3
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clr,
    fir_deconv_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC1  = 3'd1,
        MAC2  = 3'd2,
        SCALE = 3'd3,
        OUT   = 3'd4
    } state_t;

    localparam logic signed [19:0] C_K1 = 20'(K1);
    localparam logic signed [19:0] C_K2 = 20'(K2);

    state_t             state;
    logic signed [19:0] acc;
    logic signed [7:0]  x1;
    logic signed [7:0]  x2;
    logic signed [7:0]  x_out_r;
    logic               x_ovf_r;
    logic               x_valid_r;
    logic               y_ready_r;

    logic signed [19:0] prod1;
    logic signed [19:0] prod2;
    logic signed [19:0] scaled;
    logic signed [7:0]  res_x;
    logic               res_ovf;

    // 20 bits cover |y| + 2*128*128 worst case, so products never wrap.
    always_comb begin
        prod1  = C_K1 * 20'(x1);
        prod2  = C_K2 * 20'(x2);
        scaled = (K0 < 0) ? -acc : acc;
`ifdef FIR_DECONV_SAT_EN
        if (scaled > 20'sd127) begin
            res_x   = 8'sd127;
            res_ovf = 1'b1;
        end else if (scaled < -20'sd128) begin
            res_x   = -8'sd128;
            res_ovf = 1'b1;
        end else begin
            res_x   = scaled[7:0];
            res_ovf = 1'b0;
        end
`else
        res_x   = scaled[7:0];
        res_ovf = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            x1        <= '0;
            x2        <= '0;
            x_out_r   <= '0;
            x_ovf_r   <= 1'b0;
            x_valid_r <= 1'b0;
            y_ready_r <= 1'b1;
        end else if (clr) begin
            state     <= IDLE;
            acc       <= '0;
            x1        <= '0;
            x2        <= '0;
            x_valid_r <= 1'b0;
            y_ready_r <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.y_valid) begin
                        acc       <= 20'(bus.y_in);
                        y_ready_r <= 1'b0;
                        state     <= MAC1;
                    end
                end
                MAC1: begin
                    acc   <= acc - prod1;
                    state <= MAC2;
                end
                MAC2: begin
                    acc   <= acc - prod2;
                    state <= SCALE;
                end
                SCALE: begin
                    acc       <= scaled;
                    x_out_r   <= res_x;
                    x_ovf_r   <= res_ovf;
                    x_valid_r <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // History tracks what was actually emitted, not the raw accumulator.
                    if (bus.x_ready) begin
                        x2        <= x1;
                        x1        <= x_out_r;
                        x_valid_r <= 1'b0;
                        y_ready_r <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    x_valid_r <= 1'b0;
                    y_ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign bus.y_ready = y_ready_r;
    assign bus.x_out   = x_out_r;
    assign bus.x_ovf   = x_ovf_r;
    assign bus.x_valid = x_valid_r;

endmodule

`default_nettype wire

// File: tb/tb_fir_deconv.sv
// tb_fir_deconv: randomized scoreboard bench for fir_deconv against a plain-arithmetic inverse-FIR model.
`default_nettype none

module tb_fir_deconv;
    localparam int K0 = -1;
    localparam int K1 = 2;
    localparam int K2 = 3;

    typedef struct {
        logic signed [7:0] x;
        logic              ovf;
        int                cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic clr = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   transfers = 0;
    bit   rand_rdy = 1'b0;
    int   m_x1 = 0;
    int   m_x2 = 0;
    exp_t q[$];

    fir_deconv_if bus ();

    fir_deconv #(.K0(K0), .K1(K1), .K2(K2)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (clr),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Inverse FIR from the defining equation, using the emitted-output history.
    function automatic void model_push(input int y, input int acc_cyc);
        int   v;
        exp_t e;
        v = K0 * (y - K1 * m_x1 - K2 * m_x2);
`ifdef FIR_DECONV_SAT_EN
        if (v > 127) begin
            e.x = 8'sd127; e.ovf = 1'b1;
        end else if (v < -128) begin
            e.x = -8'sd128; e.ovf = 1'b1;
        end else begin
            e.x = 8'(v); e.ovf = 1'b0;
        end
`else
        e.x = 8'(v); e.ovf = 1'b0;
`endif
        e.cyc = acc_cyc;
        q.push_back(e);
        m_x2 = m_x1;
        m_x1 = int'(e.x);
    endfunction

    function automatic void model_flush();
        q.delete();
        m_x1 = 0;
        m_x2 = 0;
    endfunction

    // Presents one sample; use_x pushes the known original sample instead of the model result.
    task automatic issue(input int y, input bit use_x, input int xv);
        exp_t e;
        bit   ok = 1'b0;
        bus.y_in    = 16'(y);
        bus.y_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.y_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else if (use_x) begin
            e.x = 8'(xv); e.ovf = 1'b0; e.cyc = cyc;
            q.push_back(e);
            m_x2 = m_x1;
            m_x1 = xv;
        end else begin
            model_push(y, cyc);
        end
        @(posedge clk);
        #1 bus.y_valid = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (q.size() == 0 && !bus.x_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_done", int'(ok), 1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations on each transfer, checks latency and hold stability.
    initial begin
        bit                prev_v = 1'b0;
        logic signed [7:0] held_x = '0;
        logic              held_ovf = 1'b0;
        exp_t              e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (bus.x_valid && !prev_v) begin
                    if (q.size() == 0) chk("unexpected_x_valid", 1, 0);
                    else chk("latency_cycles", cyc - q[0].cyc, 4);
                    held_x   = bus.x_out;
                    held_ovf = bus.x_ovf;
                end else if (bus.x_valid && prev_v) begin
                    chk("hold_x_out", int'(bus.x_out), int'(held_x));
                    chk("hold_x_ovf", int'(bus.x_ovf), int'(held_ovf));
                end
                if (bus.x_valid) begin
                    chk("y_ready_in_out", int'(bus.y_ready), 0);
                    if (bus.x_ready && q.size() > 0) begin
                        e = q.pop_front();
                        chk("x_out", int'(bus.x_out), int'(e.x));
                        chk("x_ovf", int'(bus.x_ovf), int'(e.ovf));
                        transfers++;
                    end
                end
                prev_v = bus.x_valid;
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.x_ready = 1'($urandom_range(0, 1));
    end

    initial begin
        int sx1;
        int sx2;
        int t0;
        bus.y_in    = '0;
        bus.y_valid = 1'b0;
        bus.x_ready = 1'b1;

        // Asynchronous reset before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        chk("reset_y_ready", int'(bus.y_ready), 1);
        chk("reset_x_valid", int'(bus.x_valid), 0);
        chk("reset_x_out", int'(bus.x_out), 0);
        chk("reset_x_ovf", int'(bus.x_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known sequence from x = -10, -9, -8.
        issue(10, 1'b1, -10);
        issue(-11, 1'b1, -9);
        issue(-40, 1'b1, -8);
        drain();

        // Backpressure: hold OUT for 7 cycles.
        bus.x_ready = 1'b0;
        t0 = transfers;
        issue(33, 1'b0, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.x_valid) break;
        end
        chk("bp_reached_out", int'(bus.x_valid), 1);
        repeat (7) @(posedge clk);
        #1 bus.x_ready = 1'b1;
        drain();
        chk("bp_one_transfer", transfers - t0, 1);

        // Out-of-range result after fresh reset.
        do_reset();
        issue(200, 1'b0, 0);
        drain();

        // clr during MAC2 aborts the sample and clears history.
        issue(77, 1'b0, 0);
        @(posedge clk);
        #1 clr = 1'b1;
        model_flush();
        @(posedge clk);
        #1 clr = 1'b0;
        chk("clr_y_ready", int'(bus.y_ready), 1);
        repeat (6) @(posedge clk);
        #1;
        issue(5, 1'b0, 0);
        drain();

        // Async reset in SCALE discards the sample.
        issue(-300, 1'b0, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_x_valid", int'(bus.x_valid), 0);
        chk("midreset_y_ready", int'(bus.y_ready), 1);
        model_flush();
        bus.y_in    = 16'sd7;
        bus.y_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_push(7, cyc);
        @(posedge clk);
        #1 bus.y_valid = 1'b0;
        chk("first_edge_accept", int'(bus.y_ready), 0);
        drain();

        // Sweep x = -10..10 through the forward FIR, back-to-back.
        @(posedge clk);
        #1 clr = 1'b1;
        model_flush();
        @(posedge clk);
        #1 clr = 1'b0;
        sx1 = 0;
        sx2 = 0;
        for (int x = -10; x <= 10; x++) begin
            issue(K0 * x + K1 * sx1 + K2 * sx2, 1'b1, x);
            sx2 = sx1;
            sx1 = x;
        end
        drain();

        // Random samples with random downstream stalls and input gaps.
        rand_rdy = 1'b1;
        for (int n = 0; n < 150; n++) begin
            int y;
            if ($urandom_range(0, 3) == 0) y = int'($signed(16'($urandom)));
            else y = $urandom_range(0, 400) - 200;
            issue(y, 1'b0, 0);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2 bus.x_ready = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
